io_hub: RTL and testbench

- Peripheral-side responder for the processor I/O port. It answers the core's input requests (req_in/addr_in → io_in) and absorbs its output writes (out_en/addr_out/data_out).
- Each input address has a one-deep holding slot, filled by external producers through a valid/ready handshake.
- Output writes are queued as {addr, data} in a FIFO, drained by an external consumer through a valid/ready handshake.
- Sits between the core and the board-level peripherals; optionally raises the core's itr line.

---
 rtl/io_hub_pkg.sv | 28 ++
 rtl/io_fifo.sv | 62 ++++++
 rtl/io_hub.sv | 129 ++++++++++++
 tb/tb_io_hub.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_hub_pkg.sv
// Shared helpers for io_hub: width derivation, FIFO entry type for the default
// configuration, and pointer-based full/empty predicates.
package io_hub_pkg;

    localparam int IO_DEF_NUBITS = 32;
    localparam int IO_DEF_NBADDO = 3;

    typedef struct packed {
        logic [IO_DEF_NBADDO-1:0] addr;
        logic [IO_DEF_NUBITS-1:0] data;
    } io_entry_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Pointers carry one extra wrap bit above the aw address bits.
    function automatic logic ptr_full(input logic [31:0] wr, input logic [31:0] rd, input int aw);
        logic [31:0] diff;
        diff = wr ^ rd;
        return diff[aw] && ((diff & ((32'd1 << aw) - 32'd1)) == 32'd0);
    endfunction

    function automatic logic ptr_empty(input logic [31:0] wr, input logic [31:0] rd, input int aw);
        return ((wr ^ rd) & ((32'd1 << (aw + 1)) - 32'd1)) == 32'd0;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Output-write FIFO: array storage, wrap-bit pointers, registered head with
// write bypass, and a sticky flag for pushes dropped while full.
module io_fifo
    import io_hub_pkg::*;
#(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop_rdy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_head;
    logic [AW:0]      r_wr, r_rd;
    logic             r_drop;
    logic [AW:0]      w_wr_next, w_rd_next;
    logic             w_full, w_empty, w_empty_next, w_pop, w_push_ok;

    assign w_full       = ptr_full(32'(r_wr), 32'(r_rd), AW);
    assign w_empty      = ptr_empty(32'(r_wr), 32'(r_rd), AW);
    assign w_pop        = ~w_empty & i_pop_rdy;
    assign w_push_ok    = i_push & (~w_full | w_pop);
    assign w_wr_next    = r_wr + (AW+1)'(w_push_ok);
    assign w_rd_next    = r_rd + (AW+1)'(w_pop);
    assign w_empty_next = ptr_empty(32'(w_wr_next), 32'(w_rd_next), AW);

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr[AW-1:0]] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_head <= '0;
            r_drop <= 1'b0;
        end else begin
            r_wr <= w_wr_next;
            r_rd <= w_rd_next;
            // The next head may be the word being written on this same edge.
            if (!w_empty_next)
                r_head <= (w_push_ok && (r_wr[AW-1:0] == w_rd_next[AW-1:0]))
                          ? i_din : r_mem[w_rd_next[AW-1:0]];
            if (i_push && w_full && !w_pop)
                r_drop <= 1'b1;
        end
    end

    assign o_valid = ~w_empty;
    assign o_dout  = r_head;
    assign o_drop  = r_drop;

endmodule

// File: rtl/io_hub.sv
// Core I/O responder: per-address input holding slots plus a queued output path.
// Optional interrupt on slot fill is enabled by defining IO_HUB_ITR_EN.
module io_hub
    import io_hub_pkg::*;
#(
    parameter  int NUBITS = 32,
    parameter  int NUIOIN = 8,
    parameter  int NUIOOU = 8,
    parameter  int FDEPTH = 8,
    localparam int NBADDI = clog2_min1(NUIOIN),
    localparam int NBADDO = clog2_min1(NUIOOU)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_in,
    input  logic [NBADDI-1:0]        addr_in,
    output logic [NUBITS-1:0]        io_in,
    input  logic                     out_en,
    input  logic [NBADDO-1:0]        addr_out,
    input  logic [NUBITS-1:0]        data_out,
    input  logic [NUIOIN*NUBITS-1:0] src_data,
    input  logic [NUIOIN-1:0]        src_valid,
    output logic [NUIOIN-1:0]        src_ready,
    output logic [NUBITS-1:0]        snk_data,
    output logic [NBADDO-1:0]        snk_addr,
    output logic                     snk_valid,
    input  logic                     snk_ready,
    output logic                     ovf,
    output logic                     udf,
    output logic                     itr
);
    typedef struct packed {
        logic [NBADDO-1:0] addr;
        logic [NUBITS-1:0] data;
    } entry_t;

    logic [NUBITS-1:0] w_data [NUIOIN];
    logic [NUIOIN-1:0] w_valid, w_hit, w_load;
    logic [NUBITS-1:0] w_rd_data;
    logic              w_rd_valid;
    logic              r_udf;
    entry_t            w_push_entry, w_head;

    for (genvar gi = 0; gi < NUIOIN; gi++) begin : g_slot
        logic [NUBITS-1:0] r_data;
        logic              r_valid;

        assign w_hit[gi]     = req_in && (addr_in == NBADDI'(gi));
        assign src_ready[gi] = ~r_valid | w_hit[gi];
        assign w_load[gi]    = src_valid[gi] & src_ready[gi];
        assign w_data[gi]    = r_data;
        assign w_valid[gi]   = r_valid;

        // A load on the same edge as a read keeps the slot full.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (w_load[gi]) begin
                r_data  <= src_data[gi*NUBITS +: NUBITS];
                r_valid <= 1'b1;
            end else if (w_hit[gi]) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Out-of-range addresses match no slot: data 0, treated as empty.
    always_comb begin
        w_rd_data  = '0;
        w_rd_valid = 1'b0;
        for (int i = 0; i < NUIOIN; i++) begin
            if (addr_in == NBADDI'(i)) begin
                w_rd_data  = w_data[i];
                w_rd_valid = w_valid[i];
            end
        end
    end

    assign io_in = w_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_udf <= 1'b0;
        else if (req_in && !w_rd_valid)
            r_udf <= 1'b1;
    end

    assign udf = r_udf;

    assign w_push_entry = '{addr: addr_out, data: data_out};

    io_fifo #(
        .WIDTH (NBADDO + NUBITS),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .i_push    (out_en),
        .i_din     (w_push_entry),
        .i_pop_rdy (snk_ready),
        .o_valid   (snk_valid),
        .o_dout    (w_head),
        .o_drop    (ovf)
    );

    assign snk_data = w_head.data;
    assign snk_addr = w_head.addr;

`ifdef IO_HUB_ITR_EN
    logic [NUIOIN-1:0] r_valid_d;
    logic              r_itr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_d <= '0;
            r_itr     <= 1'b0;
        end else begin
            r_valid_d <= w_valid;
            r_itr     <= |(w_valid & ~r_valid_d);
        end
    end

    assign itr = r_itr;
`else
    assign itr = 1'b0;
`endif

endmodule

// File: tb/tb_io_hub.sv
// Self-checking bench for io_hub: directed scenarios plus randomized traffic
// checked against a slot/queue reference model.
module tb_io_hub;
    import io_hub_pkg::*;

    localparam int NUBITS = 32;
    localparam int NUIOIN = 8;
    localparam int NUIOOU = 8;
    localparam int FDEPTH = 8;
`ifdef IO_HUB_ITR_EN
    localparam bit ITR_ON = 1'b1;
`else
    localparam bit ITR_ON = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     req_in = 1'b0;
    logic [2:0]               addr_in = '0;
    logic [NUBITS-1:0]        io_in;
    logic                     out_en = 1'b0;
    logic [2:0]               addr_out = '0;
    logic [NUBITS-1:0]        data_out = '0;
    logic [NUIOIN*NUBITS-1:0] src_data = '0;
    logic [NUIOIN-1:0]        src_valid = '0;
    logic [NUIOIN-1:0]        src_ready;
    logic [NUBITS-1:0]        snk_data;
    logic [2:0]               snk_addr;
    logic                     snk_valid;
    logic                     snk_ready = 1'b0;
    logic                     ovf, udf, itr;

    always #5 clk = ~clk;

    io_hub #(.NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
        .out_en(out_en), .addr_out(addr_out), .data_out(data_out),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .snk_data(snk_data), .snk_addr(snk_addr), .snk_valid(snk_valid),
        .snk_ready(snk_ready), .ovf(ovf), .udf(udf), .itr(itr)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [NUBITS-1:0] m_data [NUIOIN];
    bit                m_valid [NUIOIN];
    io_entry_t         m_q [$];
    bit                m_ovf, m_udf, m_rose, m_itr;

    function automatic logic [NUIOIN-1:0] exp_src_ready();
        logic [NUIOIN-1:0] r;
        for (int i = 0; i < NUIOIN; i++)
            r[i] = !m_valid[i] || (req_in && (int'(addr_in) == i));
        return r;
    endfunction

    function automatic bit exp_itr();
        return ITR_ON ? m_itr : 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUIOIN; i++) begin
            m_data[i] = '0;
            m_valid[i] = 1'b0;
        end
        m_q.delete();
        m_ovf = 0; m_udf = 0; m_rose = 0; m_itr = 0;
    endtask

    // Apply one clock edge's worth of behaviour to the model, then advance.
    task automatic tick();
        bit rise;
        bit pop;
        int sz;
        io_entry_t e;
        logic [NUIOIN-1:0] rdy;
        rdy = exp_src_ready();
        rise = 0;
        if (req_in && !m_valid[addr_in]) m_udf = 1;
        for (int i = 0; i < NUIOIN; i++) begin
            if (src_valid[i] && rdy[i]) begin
                if (!m_valid[i]) rise = 1;
                m_data[i] = src_data[i*NUBITS +: NUBITS];
                m_valid[i] = 1;
            end else if (req_in && int'(addr_in) == i) begin
                m_valid[i] = 0;
            end
        end
        m_itr = m_rose;
        m_rose = rise;
        sz = m_q.size();
        pop = (sz > 0) && snk_ready;
        if (pop) void'(m_q.pop_front());
        if (out_en) begin
            if (sz < FDEPTH || pop) begin
                e.addr = addr_out;
                e.data = data_out;
                m_q.push_back(e);
            end else begin
                m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0; req_in = 0; addr_in = '0; out_en = 0; addr_out = '0; data_out = '0;
        src_data = '0; src_valid = '0; snk_ready = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (src_ready !== 8'hFF) begin tests_failed++; $display("FAIL reset_src_ready got %h expected ff", src_ready); end
        tests_run++; if (snk_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_snk_valid got %b expected 0", snk_valid); end
        tests_run++; if ({snk_addr, snk_data} !== 35'd0) begin tests_failed++; $display("FAIL reset_snk got %h/%h expected 0/0", snk_addr, snk_data); end
        tests_run++; if ({ovf, udf, itr} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags ovf/udf/itr got %b%b%b expected 000", ovf, udf, itr); end
        tests_run++; if (io_in !== 32'd0) begin tests_failed++; $display("FAIL reset_io_in got %h expected 0", io_in); end
        $display("[TB] reset checked");
    endtask

    task automatic test_slot_load_read();
        src_valid = 8'h08; src_data[3*NUBITS +: NUBITS] = 32'h0000_1234;
        #1; tick();
        src_valid = '0;
        #1;
        tests_run++; if (src_ready !== 8'hF7) begin tests_failed++; $display("FAIL load_src_ready got %h expected f7", src_ready); end
        req_in = 1; addr_in = 3'd3;
        #1;
        tests_run++; if (io_in !== 32'h0000_1234) begin tests_failed++; $display("FAIL read_io_in got %h expected 00001234", io_in); end
        tests_run++; if (src_ready[3] !== 1'b1) begin tests_failed++; $display("FAIL read_src_ready3 got %b expected 1", src_ready[3]); end
        tick();
        req_in = 0;
        #1;
        tests_run++; if (src_ready !== 8'hFF) begin tests_failed++; $display("FAIL after_read_src_ready got %h expected ff", src_ready); end
        tests_run++; if (udf !== 1'b0) begin tests_failed++; $display("FAIL after_read_udf got %b expected 0", udf); end
        $display("[TB] slot 3 load/read done");
    endtask

    task automatic test_empty_read();
        req_in = 1; addr_in = 3'd5;
        #1;
        tests_run++; if (io_in !== 32'd0) begin tests_failed++; $display("FAIL empty_io_in got %h expected 0", io_in); end
        tick();
        req_in = 0;
        #1;
        tests_run++; if (udf !== 1'b1) begin tests_failed++; $display("FAIL empty_udf got %b expected 1", udf); end
        $display("[TB] empty read of slot 5 done");
    endtask

    task automatic test_same_cycle();
        src_valid = 8'h04; src_data[2*NUBITS +: NUBITS] = 32'h11;
        #1; tick();
        req_in = 1; addr_in = 3'd2; src_data[2*NUBITS +: NUBITS] = 32'hA5;
        #1;
        tests_run++; if (io_in !== 32'h11) begin tests_failed++; $display("FAIL same_io_in got %h expected 11", io_in); end
        tick();
        req_in = 0; src_valid = '0;
        #1;
        tests_run++; if (src_ready[2] !== 1'b0) begin tests_failed++; $display("FAIL same_valid_kept src_ready2 got %b expected 0", src_ready[2]); end
        req_in = 1; addr_in = 3'd2;
        #1;
        tests_run++; if (io_in !== 32'hA5) begin tests_failed++; $display("FAIL same_second_read got %h expected a5", io_in); end
        tick();
        req_in = 0;
        $display("[TB] same-cycle read/load of slot 2 done");
    endtask

    task automatic test_fifo_overflow();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            out_en = 1; addr_out = 3'(k); data_out = 32'(k + 100);
            #1; tick();
        end
        addr_out = 3'd7; data_out = 32'd999;
        #1;
        tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL ovf_before_drop got %b expected 0", ovf); end
        tick();
        out_en = 0;
        #1;
        tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_after_drop got %b expected 1", ovf); end
        tick();
        tests_run++; if (snk_data !== 32'd100) begin tests_failed++; $display("FAIL head_stable got %0d expected 100", snk_data); end
        snk_ready = 1;
        for (int k = 0; k < 8; k++) begin
            #1;
            tests_run++;
            if (snk_valid !== 1'b1 || snk_addr !== 3'(k) || snk_data !== 32'(k + 100)) begin
                tests_failed++;
                $display("FAIL drain_%0d got v=%b (%0d,%0d) expected v=1 (%0d,%0d)", k, snk_valid, snk_addr, snk_data, k, k + 100);
            end
            tick();
        end
        snk_ready = 0;
        #1;
        tests_run++; if (snk_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty got %b expected 0", snk_valid); end
        $display("[TB] fifo overflow/drain done");
    endtask

    task automatic test_fifo_full_stream();
        int e;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            out_en = 1; addr_out = 3'(k); data_out = 32'(200 + k);
            #1; tick();
        end
        snk_ready = 1;
        for (int j = 0; j < 20; j++) begin
            addr_out = 3'(j); data_out = 32'(300 + j);
            #1;
            e = (j < 8) ? 200 + j : 300 + j - 8;
            tests_run++;
            if (snk_valid !== 1'b1 || snk_data !== 32'(e)) begin
                tests_failed++;
                $display("FAIL stream_%0d got v=%b %0d expected v=1 %0d", j, snk_valid, snk_data, e);
            end
            tick();
        end
        out_en = 0;
        #1;
        tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL stream_ovf got %b expected 0", ovf); end
        for (int k = 0; k < 8; k++) begin
            #1;
            tests_run++;
            if (snk_valid !== 1'b1 || snk_addr !== 3'(12 + k) || snk_data !== 32'(312 + k)) begin
                tests_failed++;
                $display("FAIL stream_drain_%0d got v=%b (%0d,%0d) expected v=1 (%0d,%0d)", k, snk_valid, snk_addr, snk_data, (12 + k) % 8, 312 + k);
            end
            tick();
        end
        snk_ready = 0;
        $display("[TB] full fifo streaming done");
    endtask

    task automatic test_itr();
        do_reset();
        src_valid = 8'h03;
        src_data[0 +: NUBITS] = 32'hC0; src_data[NUBITS +: NUBITS] = 32'hC1;
        #1; tick();
        src_valid = '0;
        #1;
        tests_run++; if (itr !== 1'b0) begin tests_failed++; $display("FAIL itr_early got %b expected 0", itr); end
        tick();
        tests_run++; if (itr !== ITR_ON) begin tests_failed++; $display("FAIL itr_pulse got %b expected %b", itr, ITR_ON); end
        tick();
        tests_run++; if (itr !== 1'b0) begin tests_failed++; $display("FAIL itr_single got %b expected 0", itr); end
        $display("[TB] itr scenario done");
    endtask

    task automatic test_random();
        logic [NUBITS-1:0] exp_io;
        for (int c = 0; c < 400; c++) begin
            req_in = ($urandom_range(0, 2) == 0);
            addr_in = 3'($urandom);
            src_valid = 8'($urandom & $urandom);
            for (int i = 0; i < NUIOIN; i++) src_data[i*NUBITS +: NUBITS] = $urandom;
            out_en = ($urandom_range(0, 2) != 0);
            addr_out = 3'($urandom);
            data_out = $urandom;
            snk_ready = ($urandom_range(0, 1) == 1);
            #1;
            exp_io = m_data[addr_in];
            tests_run++; if (io_in !== exp_io) begin tests_failed++; $display("FAIL rnd_io_in c%0d got %h expected %h", c, io_in, exp_io); end
            tests_run++; if (src_ready !== exp_src_ready()) begin tests_failed++; $display("FAIL rnd_src_ready c%0d got %h expected %h", c, src_ready, exp_src_ready()); end
            tests_run++; if (snk_valid !== (m_q.size() != 0)) begin tests_failed++; $display("FAIL rnd_snk_valid c%0d got %b expected %b", c, snk_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                tests_run++;
                if (snk_addr !== m_q[0].addr || snk_data !== m_q[0].data) begin
                    tests_failed++;
                    $display("FAIL rnd_head c%0d got (%0d,%h) expected (%0d,%h)", c, snk_addr, snk_data, m_q[0].addr, m_q[0].data);
                end
            end
            tests_run++; if ({ovf, udf} !== {m_ovf, m_udf}) begin tests_failed++; $display("FAIL rnd_flags c%0d got ovf/udf %b%b expected %b%b", c, ovf, udf, m_ovf, m_udf); end
            tests_run++; if (itr !== exp_itr()) begin tests_failed++; $display("FAIL rnd_itr c%0d got %b expected %b", c, itr, exp_itr()); end
            tick();
        end
        req_in = 0; src_valid = '0; out_en = 0; snk_ready = 0;
        $display("[TB] random traffic done");
    endtask

    initial begin
        test_reset();
        test_slot_load_read();
        test_empty_read();
        test_same_cycle();
        test_fifo_overflow();
        test_fifo_full_stream();
        test_itr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
